// File: rtl/bram_dual_port.sv
// bram_dual_port: 16 x 16-bit write port (A) read back as 64 x 4-bit nibbles (B), one clock.
// Define BRAM_DUAL_PORT_OUTPUT_REG_EN to add a second read register stage (2-cycle read latency).
module bram_dual_port #(
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        write_en,
  input  logic [3:0]  addra,
  input  logic [15:0] data_in,
  input  logic        enb,
  input  logic [5:0]  addrb,
  output logic [3:0]  data_out
);

  localparam logic [15:0] INIT_WORD = (INIT_ZERO != 0) ? 16'h0000 : 16'hxxxx;

  logic [15:0] mem [16] = '{default: INIT_WORD};
  logic [15:0] rd_word;
  logic [3:0]  rd_nibble [4];
  logic [3:0]  rd_data_reg;

  // Array contents survive reset; only the write itself is suppressed.
  always_ff @(posedge clk) begin
    if (reset_n && ena && write_en) begin
      mem[addra] <= data_in;
    end
  end

  assign rd_word = mem[addrb[5:2]];

  // Nibble 0 is the least-significant nibble of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
    assign rd_nibble[gi] = rd_word[gi*4 +: 4];
  end

  // Reads sample the array before this edge's write lands, giving read-first collisions.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_reg <= 4'h0;
    end else if (enb) begin
      rd_data_reg <= rd_nibble[addrb[1:0]];
    end
  end

`ifdef BRAM_DUAL_PORT_OUTPUT_REG_EN
  logic [3:0] out_data_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_reg <= 4'h0;
    end else if (enb) begin
      out_data_reg <= rd_data_reg;
    end
  end

  assign data_out = out_data_reg;
`else
  assign data_out = rd_data_reg;
`endif

endmodule

// File: tb/tb_bram_dual_port.sv
// Self-checking bench for bram_dual_port: table-driven vectors plus hand-written corner sequences,
// with read results checked through an expected-value queue at the configured read latency.
`timescale 1ns/1ps
module tb_bram_dual_port;

`ifdef BRAM_DUAL_PORT_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ena;
  logic        write_en;
  logic [3:0]  addra;
  logic [15:0] data_in;
  logic        enb;
  logic [5:0]  addrb;
  logic [3:0]  data_out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic        ena;
    logic        we;
    logic [3:0]  addra;
    logic [15:0] din;
    logic        enb;
    logic [5:0]  addrb;
    logic        chk;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    int         due;
    logic [5:0] addrb;
    logic [3:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[$];

  bram_dual_port #(.INIT_ZERO(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ena      (ena),
    .write_en (write_en),
    .addra    (addra),
    .data_in  (data_in),
    .enb      (enb),
    .addrb    (addrb),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=%0d checks required=completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_out(input string name, input logic [3:0] exp);
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h required=%h", name, cycle, data_out, exp);
    end else begin
      $display("ok   %s cycle=%0d data_out=%h", name, cycle, data_out);
    end
  endtask

  // Drive one cycle, advance past the edge, then retire any read whose latency has elapsed.
  task automatic step(input vec_t v);
    sb_t e;
    ena      = v.ena;
    write_en = v.we;
    addra    = v.addra;
    data_in  = v.din;
    enb      = v.enb;
    addrb    = v.addrb;
    @(posedge clk);
    #1;
    cycle++;
    if (v.chk) begin
      e.due   = cycle + LAT - 1;
      e.addrb = v.addrb;
      e.exp   = v.exp;
      sb_q.push_back(e);
    end
    while (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
      e = sb_q.pop_front();
      checks++;
      if (e.due != cycle || data_out !== e.exp) begin
        errors++;
        $display("FAIL read addrb=%0d cycle=%0d due=%0d got=%h required=%h",
                 e.addrb, cycle, e.due, data_out, e.exp);
      end else begin
        $display("ok   read addrb=%0d cycle=%0d data_out=%h", e.addrb, cycle, data_out);
      end
    end
  endtask

  function automatic vec_t wr(input logic e, input logic w, input logic [3:0] a, input logic [15:0] d);
    vec_t v;
    v = '{ena: e, we: w, addra: a, din: d, enb: 1'b0, addrb: 6'd0, chk: 1'b0, exp: 4'h0};
    return v;
  endfunction

  function automatic vec_t rd(input logic [5:0] a, input logic [3:0] x);
    vec_t v;
    v = '{ena: 1'b0, we: 1'b0, addra: 4'd0, din: 16'h0, enb: 1'b1, addrb: a, chk: 1'b1, exp: x};
    return v;
  endfunction

  // Keeps enb high with no check so a 2-stage pipeline drains its last read.
  function automatic vec_t flush();
    vec_t v;
    v = '{ena: 1'b0, we: 1'b0, addra: 4'd0, din: 16'h0, enb: 1'b1, addrb: 6'd63, chk: 1'b0, exp: 4'h0};
    return v;
  endfunction

  function automatic vec_t idle(input logic [5:0] a);
    vec_t v;
    v = '{ena: 1'b0, we: 1'b0, addra: 4'd0, din: 16'h0, enb: 1'b0, addrb: a, chk: 1'b0, exp: 4'h0};
    return v;
  endfunction

  initial begin
    vec_t v;
    reset_n  = 1'b0;
    ena      = 1'b0;
    write_en = 1'b0;
    addra    = 4'd0;
    data_in  = 16'h0;
    enb      = 1'b1;
    addrb    = 6'd0;

    // Reset held for two edges with enb high.
    for (int i = 0; i < 2; i++) begin
      v = rd(6'd5, 4'h0);
      v.chk = 1'b0;
      step(v);
      check_out("reset_hold", 4'h0);
    end
    reset_n = 1'b1;

    // Table: power-up zero, basic write/read sweep, write gating.
    vecs.push_back(rd(6'd0, 4'h0));
    vecs.push_back(flush());
    vecs.push_back(wr(1'b1, 1'b1, 4'd1, 16'h1234));
    vecs.push_back(wr(1'b1, 1'b1, 4'd2, 16'hABCD));
    vecs.push_back(rd(6'd4, 4'h4));
    vecs.push_back(rd(6'd5, 4'h3));
    vecs.push_back(rd(6'd6, 4'h2));
    vecs.push_back(rd(6'd7, 4'h1));
    vecs.push_back(rd(6'd8, 4'hD));
    vecs.push_back(rd(6'd9, 4'hC));
    vecs.push_back(rd(6'd10, 4'hB));
    vecs.push_back(rd(6'd11, 4'hA));
    vecs.push_back(flush());
    vecs.push_back(wr(1'b0, 1'b1, 4'd3, 16'hFFFF));
    vecs.push_back(wr(1'b1, 1'b0, 4'd1, 16'hFFFF));
    for (int i = 0; i < 4; i++) vecs.push_back(rd(6'(12 + i), 4'h0));
    vecs.push_back(rd(6'd4, 4'h4));
    vecs.push_back(rd(6'd7, 4'h1));
    vecs.push_back(flush());
    foreach (vecs[i]) step(vecs[i]);

    // Read-first collision on word 5.
    v = rd(6'd20, 4'h0);
    v.ena = 1'b1; v.we = 1'b1; v.addra = 4'd5; v.din = 16'h5555;
    step(v);
    step(rd(6'd20, 4'h5));
    step(flush());

    // enb low holds data_out even as addrb moves.
    step(rd(6'd4, 4'h4));
    step(flush());
    v = rd(6'd4, 4'h4);
    v.chk = 1'b0;
    step(v);
    step(v);
    step(idle(6'd9));
    check_out("enb_hold", 4'h4);
    step(idle(6'd30));
    check_out("enb_hold2", 4'h4);

    // Reset pulse mid-read clears the pipeline; array contents survive.
    step(rd(6'd8, 4'hD));
    reset_n = 1'b0;
    v = rd(6'd9, 4'h0);
    v.chk = 1'b0;
    if (LAT == 2) void'(sb_q.pop_back());
    step(v);
    check_out("reset_pulse", 4'h0);
    reset_n = 1'b1;
    step(idle(6'd11));
    check_out("post_reset_idle", 4'h0);
    step(rd(6'd4, 4'h4));
    step(rd(6'd5, 4'h3));
    step(rd(6'd6, 4'h2));
    step(rd(6'd7, 4'h1));
    step(flush());

    // Top-of-range word and nibbles.
    step(wr(1'b1, 1'b1, 4'd15, 16'hF00D));
    step(rd(6'd63, 4'hF));
    step(rd(6'd62, 4'h0));
    step(rd(6'd61, 4'h0));
    step(rd(6'd60, 4'hD));
    step(flush());
    step(idle(6'd0));

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
